// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions for the 5-stage core: ALUOp codes,
//                4-bit ALU control codes and the multi-cycle multiply
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALUOp codes produced by the main decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;

    // ALU control codes produced by the ALU decoder
    localparam logic [3:0] c_ALU_AND  = 4'd0;
    localparam logic [3:0] c_ALU_OR   = 4'd1;
    localparam logic [3:0] c_ALU_ADD  = 4'd2;
    localparam logic [3:0] c_ALU_SLL  = 4'd3;
    localparam logic [3:0] c_ALU_SRL  = 4'd4;
    localparam logic [3:0] c_ALU_SUB  = 4'd6;
    localparam logic [3:0] c_ALU_SLT  = 4'd7;
    localparam logic [3:0] c_ALU_MULT = 4'd8;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mult_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mult_datapath
//  Description : Shift-add multiplier registers. One partial-product step per
//                cycle while step is high; load seeds a new multiply.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load            - latch operands, clear acc and counter
//                step            - perform one shift-add iteration
//                operand_a/b     - multiplicand / multiplier to latch
//                last            - current step is the final one
//                acc_next        - accumulator value after this step
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_datapath
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              last,
    output logic [DATA_W-1:0] acc_next
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic [CNT_W-1:0]  cnt_q;

    // Accumulate the shifted multiplicand when the current multiplier LSB is set;
    // the sum wraps so only the low DATA_W product bits survive.
    always_comb begin
        acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last     = (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= operand_a;
            mplier_q <= operand_b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_next;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule : mult_datapath
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer
//  Description : Execute-stage MULT controller. Accepts a MULT issue, holds
//                the pipeline while the shift-add datapath iterates DATA_W
//                times, then presents the low product word for one cycle.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - EX stage holds a valid instruction
//                alu_ctrl        - ALU control code of the EX instruction
//                operand_a/b     - rs1 / rs2 values
//                flush           - kill of the EX instruction
//                stall           - freeze IF/ID/EX registers (combinational)
//                result          - product[DATA_W-1:0], registered
//                result_valid    - result qualifies this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer
    import alu_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [3:0] MULT_CODE = c_ALU_MULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    mult_state_t       state_q;
    logic [DATA_W-1:0] result_q;
    logic              valid_q;

    logic              w_accept_cond;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [DATA_W-1:0] w_acc_next;

    always_comb begin
        w_accept_cond = start && (alu_ctrl == MULT_CODE) && !flush;
        w_load        = !rst && (state_q == S_IDLE) && w_accept_cond;
        w_step        = !rst && !flush && (state_q == S_BUSY);
        // Combinational so the issuing cycle itself is already held.
        stall         = !rst && !flush &&
                        (((state_q == S_IDLE) && w_accept_cond) || (state_q == S_BUSY));
    end

    mult_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .last      (w_last),
        .acc_next  (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            // result is deliberately left alone so a killed op never disturbs it.
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (w_accept_cond) begin
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    valid_q <= 1'b0;
                    if (w_last) begin
                        state_q  <= S_DONE;
                        result_q <= w_acc_next;
                        valid_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // start is still high for the same instruction; do not re-accept.
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // A same-cycle flush or reset must suppress the DONE pulse.
    always_comb begin
        result       = result_q;
        result_valid = valid_q && !flush && !rst;
    end

endmodule : mult_sequencer
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_sequencer
//  Description : Self-checking bench for mult_sequencer. Expected products are
//                queued when a MULT is issued and popped on result_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

    localparam int c_W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     alu_ctrl;
    logic [c_W-1:0] operand_a;
    logic [c_W-1:0] operand_b;
    logic           flush;
    logic           stall;
    logic [c_W-1:0] result;
    logic           result_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic [c_W-1:0] exp_q[$];
    logic [c_W-1:0] last_result;

    typedef struct {
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic [c_W-1:0] p;
    } vec_t;

    always #5 clk = ~clk;

    mult_sequencer #(.DATA_W(c_W), .MULT_CODE(4'd8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .alu_ctrl     (alu_ctrl),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every result_valid pulse must match the oldest issued MULT.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a MULT now and follow it through BUSY and DONE, holding start.
    // Returns one cycle after DONE with start/alu_ctrl still driven.
    task automatic run_mult(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                            input logic [c_W-1:0] p);
        start     = 1'b1;
        alu_ctrl  = 4'd8;
        operand_a = a;
        operand_b = b;
        exp_q.push_back(p);
        for (int c = 0; c <= c_W + 1; c++) begin
            @(negedge clk);
            check("mult_stall",  {31'd0, stall},        {31'd0, (c <= c_W)});
            check("mult_valid",  {31'd0, result_valid}, {31'd0, (c == c_W + 1)});
            tick();
        end
        check("result_hold", result, p);
        last_result = p;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd3,          32'd5,          32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
        vecs[2] = '{32'h00012345,   32'h00000100,   32'h01234500};
        vecs[3] = '{32'd7,          32'd6,          32'h0000002A};
        vecs[4] = '{32'd0,          32'hDEADBEEF,   32'h00000000};
        vecs[5] = '{32'h80000000,   32'd2,          32'h00000000};
        vecs[6] = '{32'hDEADBEEF,   32'd1,          32'hDEADBEEF};
        vecs[7] = '{32'h0000FFFF,   32'h00010001,   32'hFFFFFFFF};

        rst = 1'b1; start = 1'b0; alu_ctrl = 4'd0; flush = 1'b0;
        operand_a = '0; operand_b = '0; last_result = '0;
        idle_cycles(3);

        // Reset state, with a MULT presented to show rst dominates.
        start = 1'b1; alu_ctrl = 4'd8; operand_a = 32'd3; operand_b = 32'd5;
        @(negedge clk);
        check("rst_stall",  {31'd0, stall},        32'd0);
        check("rst_valid",  {31'd0, result_valid}, 32'd0);
        check("rst_result", result,                32'd0);
        tick();
        start = 1'b0; alu_ctrl = 4'd0;
        rst = 1'b0;
        tick();

        // Table-driven products, one idle cycle between each.
        foreach (vecs[i]) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].p);
            start = 1'b0;
            tick();
        end

        // Non-MULT code held for 5 cycles: never stalls, never fires.
        start = 1'b1; alu_ctrl = 4'd2; operand_a = 32'd4; operand_b = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("add_stall", {31'd0, stall},        32'd0);
            check("add_valid", {31'd0, result_valid}, 32'd0);
            tick();
        end
        // Still IDLE: a MULT right after is accepted immediately.
        run_mult(32'd11, 32'd13, 32'd143);
        start = 1'b0;
        tick();

        // Flush during BUSY at T+10.
        start = 1'b1; alu_ctrl = 4'd8; operand_a = 32'd3; operand_b = 32'd5;
        idle_cycles(10);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'd0, stall},        32'd0);
        check("flush_valid", {31'd0, result_valid}, 32'd0);
        tick();
        flush = 1'b0;
        idle_cycles(40);
        check("flush_result_kept", result, last_result);
        run_mult(32'd7, 32'd6, 32'h2A);
        start = 1'b0;
        tick();

        // Flush in IDLE blocks acceptance.
        start = 1'b1; alu_ctrl = 4'd8; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_not_busy", {31'd0, stall}, 32'd0);
        tick();

        // Hold through DONE then back-to-back MULT at T+34.
        run_mult(32'd10, 32'd10, 32'd100);
        run_mult(32'd2, 32'd9, 32'h12);
        start = 1'b0;
        tick();

        // Reset mid-operation at T+5.
        start = 1'b1; alu_ctrl = 4'd8; operand_a = 32'd3; operand_b = 32'd5;
        idle_cycles(5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", {31'd0, stall},        32'd0);
        check("midrst_valid", {31'd0, result_valid}, 32'd0);
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("midrst_result", result,        32'd0);
        check("midrst_idle",   {31'd0, stall}, 32'd0);
        idle_cycles(40);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mult_sequencer
`default_nettype wire
